// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline registers.
// No logic: the only function here builds the IF/ID bubble value.
package rv_pipe_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [XLEN-1:0] nop);
        if_id_t b;
        b.instr    = nop;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: 1-cycle capture; flush beats stall, reset/flush load a bubble.
// Backpressure: stall holds the current contents indefinitely.
module if_id_reg
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t in_dat,
    output if_id_t out_dat
);
    if_id_t if_id_q;
    if_id_t if_id_d;

    always_comb begin
        if_id_d = if_id_q;
        if (flush) begin
            if_id_d = if_id_bubble(BUBBLE_INSTR);
        end else if (!stall) begin
            if_id_d = in_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_q <= if_id_bubble(BUBBLE_INSTR);
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign out_dat = if_id_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses imem combinationally, 1-cycle fetch-to-decode.
// Backpressure: stall_f holds the PC, stall_d holds IF/ID; an aligned redirect overrides stall_f.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = rv_pipe_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);
    import rv_pipe_pkg::*;

    logic [31:0] pc_f_q, pc_f_d;
    logic        misalign_q, misalign_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4_f;
    logic        target_misaligned;
    logic        if_id_load;
    if_id_t      if_id_in;
    if_id_t      if_id_out;

    always_comb begin
        pc_plus4_f        = pc_f_q + 32'd4;
        target_misaligned = pc_target_e[1:0] != 2'b00;
        if_id_load        = !flush_d && !stall_d;

        pc_f_d = pc_f_q;
        if (pc_src_e && !target_misaligned) begin
            pc_f_d = pc_target_e;
        end else if (!stall_f) begin
            pc_f_d = pc_plus4_f;
        end

        // A misaligned target is dropped; fetch carries on sequentially.
        misalign_d    = misalign_q | (pc_src_e & target_misaligned);
        fetch_count_d = fetch_count_q + {31'd0, if_id_load};

        if_id_in.instr    = imem_rdata;
        if_id_in.pc       = pc_f_q;
        if_id_in.pc_plus4 = pc_plus4_f;
        if_id_in.valid    = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q        <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_f_q        <= pc_f_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .BUBBLE_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall_d),
        .flush  (flush_d),
        .in_dat (if_id_in),
        .out_dat(if_id_out)
    );

    assign imem_addr    = pc_f_q;
    assign instr_d      = if_id_out.instr;
    assign pc_d         = if_id_out.pc;
    assign pc_plus4_d   = if_id_out.pc_plus4;
    assign valid_d      = if_id_out.valid;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table with a scoreboard queue, plus async-reset and PC-wrap sequences.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] imem_addr, imem_rdata, instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d, misalign_err;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_p4, w_cnt;
    logic        w_valid, w_mis;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];
    assign w_rdata    = mem[w_addr[7:2]];

    fetch_stage u_dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .valid_d(valid_d), .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .instr_d(w_instr), .pc_d(w_pc), .pc_plus4_d(w_p4),
        .valid_d(w_valid), .misalign_err(w_mis), .fetch_count(w_cnt)
    );

    typedef struct {
        logic        sf, sd, fl, src;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_pcd;
        logic        e_v;
        logic [31:0] e_cnt;
        logic        e_mis;
    } vec_t;

    typedef struct {
        logic [31:0] pc, instr, pcd, p4;
        logic        v;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input vec_t v);
        exp_t e;
        e.pc    = v.e_pc;
        e.pcd   = v.e_pcd;
        e.v     = v.e_v;
        e.instr = v.e_v ? mem[v.e_pcd[7:2]] : NOP;
        e.p4    = v.e_v ? v.e_pcd + 32'd4 : 32'd0;
        e.cnt   = v.e_cnt;
        e.mis   = v.e_mis;
        return e;
    endfunction

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".imem_addr"},    imem_addr,            e.pc);
        chk({tag, ".instr_d"},      instr_d,              e.instr);
        chk({tag, ".pc_d"},         pc_d,                 e.pcd);
        chk({tag, ".pc_plus4_d"},   pc_plus4_d,           e.p4);
        chk({tag, ".valid_d"},      {31'd0, valid_d},     {31'd0, e.v});
        chk({tag, ".fetch_count"},  fetch_count,          e.cnt);
        chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, e.mis});
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fl, input logic src,
                         input logic [31:0] tgt);
        stall_f     = sf;
        stall_d     = sd;
        flush_d     = fl;
        pc_src_e    = src;
        pc_target_e = tgt;
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | (i << 2);
        mem[0] = 32'h0062E3B3;
        mem[1] = 32'h0062F433;

        //          sf sd fl src tgt           pc            pc_d          v  cnt  mis
        vecs[0]  = '{0, 0, 0, 0, 32'h0,  32'h04, 32'h00, 1, 32'd1,  0};
        vecs[1]  = '{0, 0, 0, 0, 32'h0,  32'h08, 32'h04, 1, 32'd2,  0};
        vecs[2]  = '{1, 1, 0, 0, 32'h0,  32'h08, 32'h04, 1, 32'd2,  0};
        vecs[3]  = '{1, 1, 0, 0, 32'h0,  32'h08, 32'h04, 1, 32'd2,  0};
        vecs[4]  = '{0, 0, 0, 0, 32'h0,  32'h0C, 32'h08, 1, 32'd3,  0};
        vecs[5]  = '{1, 0, 0, 0, 32'h0,  32'h0C, 32'h0C, 1, 32'd4,  0};
        vecs[6]  = '{1, 0, 0, 0, 32'h0,  32'h0C, 32'h0C, 1, 32'd5,  0};
        vecs[7]  = '{0, 1, 0, 0, 32'h0,  32'h10, 32'h0C, 1, 32'd5,  0};
        vecs[8]  = '{1, 0, 1, 1, 32'h40, 32'h40, 32'h00, 0, 32'd5,  0};
        vecs[9]  = '{0, 0, 0, 0, 32'h0,  32'h44, 32'h40, 1, 32'd6,  0};
        vecs[10] = '{0, 0, 0, 1, 32'h42, 32'h48, 32'h44, 1, 32'd7,  1};
        vecs[11] = '{0, 0, 0, 0, 32'h0,  32'h4C, 32'h48, 1, 32'd8,  1};
        vecs[12] = '{1, 0, 0, 1, 32'h43, 32'h4C, 32'h4C, 1, 32'd9,  1};
        vecs[13] = '{0, 1, 1, 0, 32'h0,  32'h50, 32'h00, 0, 32'd9,  1};
        vecs[14] = '{0, 0, 0, 1, 32'h80, 32'h80, 32'h50, 1, 32'd10, 1};
        vecs[15] = '{0, 0, 0, 0, 32'h0,  32'h84, 32'h80, 1, 32'd11, 1};

        rst = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        #12;
        e = '{32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0};
        chk_all("reset", e);

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].sf, vecs[i].sd, vecs[i].fl, vecs[i].src, vecs[i].tgt);
            sb.push_back(mk(vecs[i]));
            @(posedge clk);
            @(negedge clk);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: got empty queue expected entry for vec %0d", i);
            end else begin
                e = sb.pop_front();
                chk_all($sformatf("vec%0d", i), e);
            end
        end

        // Async reset between edges: state must clear before the next clk edge.
        drive(0, 0, 0, 0, 32'h0);
        #2 rst = 1'b1;
        #1;
        e = '{32'h0, NOP, 32'h0, 32'h0, 1'b0, 32'd0, 1'b0};
        chk_all("async_rst", e);
        chk("wrap_rst.imem_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_rst.valid_d", {31'd0, w_valid}, 32'd0);
        #1 rst = 1'b0;

        @(posedge clk);
        @(negedge clk);
        e = '{32'h4, 32'h0062E3B3, 32'h0, 32'h4, 1'b1, 32'd1, 1'b0};
        chk_all("post_rst1", e);
        chk("wrap1.imem_addr",  w_addr,  32'h0);
        chk("wrap1.pc_d",       w_pc,    32'hFFFF_FFFC);
        chk("wrap1.pc_plus4_d", w_p4,    32'h0);
        chk("wrap1.instr_d",    w_instr, mem[63]);
        chk("wrap1.valid_d",    {31'd0, w_valid}, 32'd1);

        @(posedge clk);
        @(negedge clk);
        e = '{32'h8, 32'h0062F433, 32'h4, 32'h8, 1'b1, 32'd2, 1'b0};
        chk_all("post_rst2", e);
        chk("wrap2.imem_addr",  w_addr,  32'h4);
        chk("wrap2.pc_d",       w_pc,    32'h0);
        chk("wrap2.instr_d",    w_instr, 32'h0062E3B3);
        chk("wrap2.fetch_count", w_cnt,  32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the instruction memory and downstream-feeding decode.
- Owns the program counter and drives the instruction memory word address.
- Captures the combinational read data into the IF/ID pipeline register with stall, flush and branch-redirect control.
- Keeps a sticky misaligned-target flag and a fetched-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) inserted into decode on flush/reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- stall_f  input  1  hold PC (hazard unit).
- stall_d  input  1  hold IF/ID register.
- flush_d  input  1  replace IF/ID contents with bubble.
- pc_src_e  input  1  taken branch/jump resolved in execute.
- pc_target_e  input  32  redirect target from execute.
- imem_addr  output  32  byte address to instruction memory; equals pc_f.
- imem_rdata  input  32  combinational read data from instruction memory.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC.
- pc_plus4_d  output  32  IF/ID PC+4.
- valid_d  output  1  IF/ID holds a real instruction.
- misalign_err  output  1  sticky: a redirect target had [1:0] != 0.
- fetch_count  output  32  count of instructions loaded into IF/ID with valid=1.

Behaviour:
- Reset (async, rst=1):
  - pc_f=RESET_PC; instr_d=NOP_INSTR; pc_d=0; pc_plus4_d=0; valid_d=0; misalign_err=0; fetch_count=0.
  - Outputs take these values immediately, without waiting for a clock edge.
- Fetch:
  - imem_addr=pc_f combinationally; imem_rdata is valid in the same cycle.
  - Fetch-to-decode latency is 1 clock.
- PC next-state, priority high to low:
  - pc_src_e=1 with pc_target_e[1:0]==0: pc_f <= pc_target_e, even if stall_f=1.
  - pc_src_e=1 with pc_target_e[1:0]!=0: pc_f <= pc_f+4 (unless stall_f, then hold); misalign_err <= 1, sticky until reset.
  - stall_f=1: hold pc_f.
  - Otherwise: pc_f <= pc_f+4. Arithmetic is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID next-state, priority high to low:
  - flush_d=1: instr_d<=NOP_INSTR, pc_d<=0, pc_plus4_d<=0, valid_d<=0. Flush beats stall_d.
  - stall_d=1: hold all IF/ID fields.
  - Otherwise: instr_d<=imem_rdata, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
- fetch_count increments by 1 on every edge where IF/ID loads with valid_d<=1; wraps at 2^32.
- The first edge after reset deassertion loads valid_d=1 (the instruction at RESET_PC) unless flushed or stalled.
- Simultaneous stall_f=1 and stall_d=0 is legal: the same pc_f is re-captured into IF/ID each cycle.
- The hazard unit drives flush_d together with pc_src_e; this block does not internally flush on pc_src_e.
- Reset asserted mid-operation returns all state to reset values immediately; any pending redirect is lost.

Decomposition:
- Shared package rv_pipe_pkg:
  - NOP_INSTR constant.
  - RESET_PC default.
  - XLEN=32.
  - if_id_t struct {instr, pc, pc_plus4, valid}.
- One natural sub-module, if_id_reg: the IF/ID register with flush/stall priority and async reset to bubble; reused pattern for later pipeline registers.
- The PC mux and counters stay in fetch_stage.

Test Plan:
- Reset then free-run 3 clocks with a memory holding word0=32'h0062E3B3, word1=32'h0062F433 -> imem_addr 0,4,8; after edge 1 instr_d=32'h0062E3B3, pc_d=0, pc_plus4_d=4, valid_d=1; after edge 2 instr_d=32'h0062F433, pc_d=4; fetch_count=3 after edge 3.
- stall_f=1 and stall_d=1 for 2 cycles at pc_f=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged; release -> pc_f=12 next edge.
- pc_src_e=1, pc_target_e=32'h40, flush_d=1, stall_f=1 in the same cycle -> next edge pc_f=32'h40, instr_d=32'h13, valid_d=0; following edge pc_d=32'h40.
- pc_src_e=1, pc_target_e=32'h42 -> misalign_err=1 stays set, pc_f advances by 4, no redirect; clears only on rst.
- RESET_PC=32'hFFFF_FFFC, no stalls -> pc_f goes 32'hFFFF_FFFC then 0; pc_plus4_d for the first instruction =0.
- Assert rst asynchronously between edges mid-run -> all outputs at reset values before the next clk edge; first edge after release loads the RESET_PC instruction.
